// File: rtl/idex_pkg.sv
// Shared types and sizing helpers for the ID/EX pipeline register and its skid buffer.
package idex_pkg;

  localparam int ALU_FUNCT_BITS_DEF = 3;

  // Field order is MSB first; PCEn is the top bit of the packed bundle.
  typedef struct packed {
    logic                          PCEn;
    logic                          RegWrite;
    logic                          ALU1Src;
    logic                          RegDst;
    logic [ALU_FUNCT_BITS_DEF-1:0] ALU1Cntrl;
    logic [ALU_FUNCT_BITS_DEF-1:0] ALU2Cntrl;
    logic                          MemWrite;
    logic                          MemRead;
    logic                          MemtoReg;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t SIDE_EFFECT_MASK = '{PCEn: 1'b1, RegWrite: 1'b1, MemWrite: 1'b1,
                                         MemRead: 1'b1, default: '0};

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b10,
    FULL  = 2'b11
  } skidState_t;

  function automatic int payloadWidth(input int ctrlW, input int busW, input int regW,
                                      input int nSrc);
    return ctrlW + (nSrc + 1) * busW + 2 * regW;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer with registered ready, flush, and masked clearing of the
// output register whenever it goes empty.
module pipe_skid_buf
  import idex_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] CLEAR_MASK = '0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData
);

  skidState_t       state;
  skidState_t       nextState;
  logic [WIDTH-1:0] skidData;
  logic             accept;
  logic             consume;
  logic             loadIn;
  logic             loadSkid;
  logic             loadFromSkid;
  logic             clearOut;

  assign OutValid = (state != EMPTY);
  assign InReady  = (state != FULL);
  assign accept   = InValid & InReady;
  assign consume  = OutValid & OutReady;

  always_comb begin
    nextState    = state;
    loadIn       = 1'b0;
    loadSkid     = 1'b0;
    loadFromSkid = 1'b0;
    clearOut     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          loadIn    = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        if (accept && consume) begin
          loadIn = 1'b1;
        end else if (accept) begin
          loadSkid  = 1'b1;
          nextState = FULL;
        end else if (consume) begin
          clearOut  = 1'b1;
          nextState = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          loadFromSkid = 1'b1;
          nextState    = BUSY;
        end
      end
      default: nextState = EMPTY;
    endcase
    // Flush drops everything held or arriving; a same-cycle consume still completes.
    if (Flush) begin
      nextState    = EMPTY;
      loadIn       = 1'b0;
      loadSkid     = 1'b0;
      loadFromSkid = 1'b0;
      clearOut     = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= EMPTY;
      OutData  <= '0;
      skidData <= '0;
    end else begin
      state <= nextState;
      if (loadIn) begin
        OutData <= InData;
      end else if (loadFromSkid) begin
        OutData <= skidData;
      end else if (clearOut) begin
        OutData <= OutData & ~CLEAR_MASK;
      end
      if (loadSkid) begin
        skidData <= InData;
      end
    end
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: skid-buffered payload with side-effect zeroing on bubbles
// and a saturating back-pressure cycle counter.
module idex_pipe_reg
  import idex_pkg::*;
#(
  parameter  int BUS_WIDTH       = 32,
  parameter  int ALU_FUNCT_BITS  = 3,
  parameter  int REGISTER_SIZE   = 6,
  parameter  int NUM_SRC         = 3,
  parameter  int STALL_CNT_WIDTH = 16,
  localparam int CtrlWidth       = CTRL_W + 2 * (ALU_FUNCT_BITS - ALU_FUNCT_BITS_DEF)
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         ValidD,
  output logic                         ReadyD,
  input  logic                         Flush,
  input  logic [CtrlWidth-1:0]         CtrlD,
  input  logic [NUM_SRC*BUS_WIDTH-1:0] SrcD,
  input  logic [BUS_WIDTH-1:0]         SignImmD,
  input  logic [REGISTER_SIZE-1:0]     RtD,
  input  logic [REGISTER_SIZE-1:0]     RdD,
  output logic                         ValidE,
  input  logic                         ReadyE,
  output logic [CtrlWidth-1:0]         CtrlE,
  output logic [NUM_SRC*BUS_WIDTH-1:0] SrcE,
  output logic [BUS_WIDTH-1:0]         SignImmE,
  output logic [REGISTER_SIZE-1:0]     RtE,
  output logic [REGISTER_SIZE-1:0]     RdE,
  output logic [STALL_CNT_WIDTH-1:0]   StallCnt
);

  localparam int PayW = payloadWidth(CtrlWidth, BUS_WIDTH, REGISTER_SIZE, NUM_SRC);

  // The ALU fields never carry side effects, so the mask stretches to any ALU width.
  localparam logic [CtrlWidth-1:0] CtrlMask = {
    SIDE_EFFECT_MASK.PCEn, SIDE_EFFECT_MASK.RegWrite,
    SIDE_EFFECT_MASK.ALU1Src, SIDE_EFFECT_MASK.RegDst,
    {(2 * ALU_FUNCT_BITS){1'b0}},
    SIDE_EFFECT_MASK.MemWrite, SIDE_EFFECT_MASK.MemRead, SIDE_EFFECT_MASK.MemtoReg
  };
  localparam logic [PayW-1:0] ClearMask = {CtrlMask, {(PayW - CtrlWidth){1'b0}}};

  logic [PayW-1:0] payloadD;
  logic [PayW-1:0] payloadE;

  assign payloadD = {CtrlD, SrcD, SignImmD, RtD, RdD};
  assign {CtrlE, SrcE, SignImmE, RtE, RdE} = payloadE;

  pipe_skid_buf #(
    .WIDTH     (PayW),
    .CLEAR_MASK(ClearMask)
  ) skidBuf (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .Flush   (Flush),
    .InValid (ValidD),
    .InReady (ReadyD),
    .InData  (payloadD),
    .OutValid(ValidE),
    .OutReady(ReadyE),
    .OutData (payloadE)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      StallCnt <= '0;
    end else if (ValidE && !ReadyE && !(&StallCnt)) begin
      StallCnt <= StallCnt + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg (NUM_SRC=4, 3-bit stall counter) with a payload scoreboard.
module tb_idex_pipe_reg;

  localparam int PAY_W = 185;
  localparam logic [12:0] SE_MASK = 13'h1806;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         ValidD;
  logic         ReadyD;
  logic         Flush;
  logic [12:0]  CtrlD;
  logic [127:0] SrcD;
  logic [31:0]  SignImmD;
  logic [5:0]   RtD;
  logic [5:0]   RdD;
  logic         ValidE;
  logic         ReadyE;
  logic [12:0]  CtrlE;
  logic [127:0] SrcE;
  logic [31:0]  SignImmE;
  logic [5:0]   RtE;
  logic [5:0]   RdE;
  logic [2:0]   StallCnt;

  int nCompared   = 0;
  int nMismatched = 0;
  bit monOn       = 1'b0;
  logic [PAY_W-1:0] sb[$];

  idex_pipe_reg #(
    .BUS_WIDTH      (32),
    .ALU_FUNCT_BITS (3),
    .REGISTER_SIZE  (6),
    .NUM_SRC        (4),
    .STALL_CNT_WIDTH(3)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .ValidD  (ValidD),
    .ReadyD  (ReadyD),
    .Flush   (Flush),
    .CtrlD   (CtrlD),
    .SrcD    (SrcD),
    .SignImmD(SignImmD),
    .RtD     (RtD),
    .RdD     (RdD),
    .ValidE  (ValidE),
    .ReadyE  (ReadyE),
    .CtrlE   (CtrlE),
    .SrcE    (SrcE),
    .SignImmE(SignImmE),
    .RtE     (RtE),
    .RdE     (RdE),
    .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  // Every instruction carries all four side-effect bits set so bubble zeroing is visible.
  function automatic logic [PAY_W-1:0] mkPayload(input logic [5:0] rd);
    logic [12:0] ctrl;
    logic [31:0] lane0, lane1, lane2, lane3;
    ctrl  = {2'b11, rd[1:0], rd[2:0], ~rd[2:0], 3'b111};
    lane0 = 32'h0000_000F + {26'd0, rd};
    lane1 = 32'h1000_0000 | {26'd0, rd};
    lane2 = 32'h2000_0000 | {26'd0, rd};
    lane3 = (rd == 6'd1) ? 32'hDEAD_BEEF : (32'h3000_0000 | {26'd0, rd});
    return {ctrl, lane3, lane2, lane1, lane0, 32'hFFFF_F000 | {26'd0, rd}, rd + 6'd20, rd};
  endfunction

  task automatic checkOutput(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [5:0] rd,
                               input logic re, input logic fl,
                               input logic expValidE, input logic expReadyD);
    ValidD = v;
    {CtrlD, SrcD, SignImmD, RtD, RdD} = mkPayload(rd);
    ReadyE = re;
    Flush  = fl;
    @(negedge CLK);
    checkOutput({tag, ".ValidE"}, 200'(ValidE), 200'(expValidE));
    checkOutput({tag, ".ReadyD"}, 200'(ReadyD), 200'(expReadyD));
    if (v && expReadyD && !fl && RSTn) sb.push_back(mkPayload(rd));
  endtask

  // Scoreboard: every consume pops the oldest accepted instruction; bubbles must be side-effect free.
  always @(negedge CLK) begin
    if (monOn) begin
      if (ValidE === 1'b1 && ReadyE === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedDelivery.RdE", 200'(RdE), 200'hFFFF);
        end else begin
          checkOutput("delivered", 200'({CtrlE, SrcE, SignImmE, RtE, RdE}), 200'(sb.pop_front()));
        end
      end
      if (ValidE === 1'b0) checkOutput("bubbleCtrl", 200'(CtrlE & SE_MASK), 200'd0);
    end
  end

  initial begin
    RSTn = 1'b0; ValidD = 1'b1; Flush = 1'b0; ReadyE = 1'b0;
    {CtrlD, SrcD, SignImmD, RtD, RdD} = mkPayload(6'd33);
    tick();
    tick();
    @(negedge CLK);
    checkOutput("reset.ValidE", 200'(ValidE), 200'd0);
    checkOutput("reset.ReadyD", 200'(ReadyD), 200'd1);
    checkOutput("reset.StallCnt", 200'(StallCnt), 200'd0);
    checkOutput("reset.payload", 200'({CtrlE, SrcE, SignImmE, RtE, RdE}), 200'd0);
    tick();
    RSTn  = 1'b1;
    monOn = 1'b1;

    // Back-to-back stream with execute always ready.
    applyStimulus("s1", 1'b1, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    applyStimulus("s2", 1'b1, 6'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("lane3", 200'(SrcE[127:96]), 200'h0DEAD_BEEF);
    checkOutput("lane0", 200'(SrcE[31:0]), 200'h10);
    tick();
    applyStimulus("s3", 1'b1, 6'd3, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("s4", 1'b1, 6'd4, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("s5", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("s6", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1); tick();

    // Back-pressure: Rd=5 held, Rd=6 into skid, Rd=7 refused then retried.
    applyStimulus("bp5", 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    applyStimulus("bp6", 1'b1, 6'd6, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("bp7", 1'b1, 6'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp.heldRd", 200'(RdE), 200'd5);
    tick();
    applyStimulus("bpRel", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    applyStimulus("bp7b", 1'b1, 6'd7, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("bpDrain", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("bpIdle", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp.sbEmpty", 200'(sb.size()), 200'd0);
    tick();

    // Flush while FULL with a new instruction arriving.
    applyStimulus("fl8", 1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    applyStimulus("fl11", 1'b1, 6'd11, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("fl9", 1'b1, 6'd9, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    sb.delete();
    applyStimulus("flPost", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flPost.sideFx", 200'(CtrlE & SE_MASK), 200'd0);
    tick();
    applyStimulus("flIdle", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1); tick();

    // Flush together with consume: Rd=12 delivered, Rd=13 in skid discarded.
    applyStimulus("fc12", 1'b1, 6'd12, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    applyStimulus("fc13", 1'b1, 6'd13, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("fcFlush", 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    sb.delete();
    applyStimulus("fcPost", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1); tick();

    // Stall counter counts and saturates at 7, survives drain.
    RSTn = 1'b0; tick(); RSTn = 1'b1;
    applyStimulus("st14", 1'b1, 6'd14, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("st.cleared", 200'(StallCnt), 200'd0);
    tick();
    for (int i = 0; i <= 10; i++) begin
      applyStimulus("stall", 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("stallCnt%0d", i), 200'(StallCnt), 200'((i > 7) ? 7 : i));
      checkOutput($sformatf("stallRd%0d", i), 200'(RdE), 200'd14);
      tick();
    end
    applyStimulus("stDrain", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("stIdle", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("st.held", 200'(StallCnt), 200'd7);
    tick();

    // Reset in FULL discards both entries; next instruction accepted at once.
    applyStimulus("rs15", 1'b1, 6'd15, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    applyStimulus("rs16", 1'b1, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    RSTn = 1'b0;
    applyStimulus("rs17", 1'b1, 6'd17, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    sb.delete();
    RSTn = 1'b1;
    applyStimulus("rs18", 1'b1, 6'd18, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rs.StallCnt", 200'(StallCnt), 200'd0);
    checkOutput("rs.payload", 200'({CtrlE, SrcE, SignImmE, RtE, RdE}), 200'd0);
    tick();
    applyStimulus("rsDeliver", 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    applyStimulus("rsIdle", 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("final.sbEmpty", 200'(sb.size()), 200'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/idex_pipe_reg.md
# idex_pipe_reg

Parametrised decode-to-execute pipeline register for the CPU_NN core, replacing the free-running ID/EX latch. Carries the control bundle, NUM_SRC source-operand lanes, the sign-extended immediate and Rt/Rd. Adds a valid/ready handshake with a one-entry skid buffer, so execute back-pressure stalls decode without losing an instruction. Adds a flush input that inserts bubbles on branch/mispredict, and a saturating stall-cycle counter for performance analysis.

## Interface
- BUS_WIDTH, 32, operand/immediate width
- ALU_FUNCT_BITS, 3, width of each ALU control field
- REGISTER_SIZE, 6, register-index width
- NUM_SRC, 3, number of source-operand lanes (≥1)
- STALL_CNT_WIDTH, 16, stall counter width

Ports:
- CLK  in  1  sole clock, all state updates on rising edge
- RSTn  in  1  synchronous, active-low reset
- ValidD  in  1  decode presents an instruction
- ReadyD  out  1  stage can accept; registered, equals "skid entry empty"
- Flush  in  1  kill all held and incoming instructions this cycle
- CtrlD  in  CTRL_W  packed control bundle: PCEn, RegWrite, ALU1Src, RegDst, ALU1Cntrl, ALU2Cntrl, MemWrite, MemRead, MemtoReg
- SrcD  in  NUM_SRC*BUS_WIDTH  packed operands, lane 0 in LSBs
- SignImmD  in  BUS_WIDTH  immediate
- RtD, RdD  in  REGISTER_SIZE each  register indices
- ValidE  out  1  output payload valid
- ReadyE  in  1  execute consumes payload
- CtrlE, SrcE, SignImmE, RtE, RdE  out  same widths  registered payload
- StallCnt  out  STALL_CNT_WIDTH  cycles with ValidE=1 and ReadyE=0, saturating

## Operation
- Transfers: accept = ValidD & ReadyD; consume = ValidE & ReadyE.
- State, encoded from (ValidE, skid valid):
  - EMPTY (0,0)
  - BUSY (1,0)
  - FULL (1,1)
- EMPTY: accept → load output regs, go to BUSY.
- BUSY:
  - accept & consume → reload output regs, stay in BUSY.
  - accept & !consume → write skid, go to FULL.
  - consume only → go to EMPTY.
- FULL: ReadyD=0, so accept is impossible. consume → move skid to output regs, go to BUSY.
- Flush (highest priority below reset):
  - Next state is EMPTY and any incoming instruction is dropped.
  - Side-effect controls (PCEn, RegWrite, MemWrite, MemRead) are driven to 0 in the output regs.
  - Other payload fields hold their values; they are don't-care while ValidE=0.
- Whenever ValidE=0, the side-effect control bits at the output are 0. This applies after reset, flush and drain, so downstream may ignore ValidE for write enables.
- StallCnt:
  - Increments each cycle ValidE & !ReadyE, saturates at all-ones.
  - Not cleared by Flush; cleared only by reset.
- Payload is passed unaltered; no arithmetic on data.

## Timing
- Latency: accept at edge N → ValidE=1 with that payload after edge N (visible in cycle N+1).
- Throughput: 1 instruction/cycle while ReadyE=1.
- ReadyD is registered, so a deassertion by execute takes one cycle to reach decode. The skid entry absorbs the instruction accepted in that cycle.
- ValidE and payload must remain stable while ValidE & !ReadyE (AXI-style rule). ValidD is not required to be held.
- Reset (RSTn=0 at an edge):
  - ValidE=0, skid empty, ReadyD=1, StallCnt=0, all CtrlE/SrcE/SignImmE/RtE/RdE=0.
  - ValidD is ignored in the reset cycle.
  - Reset mid-stall discards both held instructions.
- Flush and consume in the same cycle: the consumed instruction counts as delivered; the skid content is discarded.
- Flush in FULL: both entries are discarded and ReadyD=1 next cycle.

## Structure
- Package idex_pkg holds:
  - ctrl_t packed struct and CTRL_W
  - payload width function of the parameters
  - SIDE_EFFECT_MASK constant used by flush/bubble zeroing
- One sub-module, pipe_skid_buf: a generic WIDTH-parameterised one-entry skid buffer with valid/ready and flush.
- idex_pipe_reg instantiates pipe_skid_buf on the packed payload and adds control-bit zeroing and StallCnt.

## Test plan
- Reset, then stream 4 instructions (Rd=1..4, SrcD lane0=0x10..0x13) with ReadyE=1 → each appears 1 cycle later, back-to-back, ValidE stays 1 for 4 cycles.
- Hold ReadyE=0 while streaming Rd=5,6,7 → ReadyD drops after the 2nd accept. Rd=5 is held on the output, Rd=6 is in skid, Rd=7 is not accepted. After ReadyE=1, delivery order is 5,6,7 with none lost or duplicated.
- FULL state, assert Flush with ValidD=1 (Rd=9) → next cycle ValidE=0, RegWriteE=MemWriteE=MemReadE=PCEnE=0, ReadyD=1, and Rd=9 is never delivered.
- ReadyE=0 with ValidE=1 for 5 cycles → StallCnt=5. With STALL_CNT_WIDTH=3 and a 10-cycle stall, StallCnt saturates at 7.
- Drive RSTn=0 during FULL → next cycle all outputs are 0, ReadyD=1, and a new instruction is accepted immediately after RSTn=1.
- NUM_SRC=1 and NUM_SRC=4 builds → lanes map correctly (lane 3 = 0xDEADBEEF appears at SrcE[127:96]).
